// File: rtl/step_clock_gen_pkg.sv
// Shared encodings for the step clock generator and the core it drives.
// Holds the run-mode encoding, debounce states and the stage wrap rule.
package step_clock_gen_pkg;

    localparam logic RUN_AUTO = 1'b1;
    localparam logic [2:0] STAGE_MAX = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } deb_state_t;

    // Same wrap rule as the core's stage sequencer
    function automatic logic [2:0] stage_next(input logic [2:0] s);
        return (s >= STAGE_MAX) ? 3'd1 : s + 3'd1;
    endfunction

endpackage

// File: rtl/step_clock_gen_if.sv
// Board-side bundle of the step clock generator: mode/button in,
// step strobe, stretched step clock, stage mirror and held level out.
interface step_clock_gen_if;

    logic       RUNTYPE;
    logic       STAGE_BTN;
    logic       STEP_PULSE;
    logic       STEP_CLK;
    logic [2:0] STAGE_NO;
    logic       BTN_HELD;

    modport master (
        output RUNTYPE, STAGE_BTN,
        input  STEP_PULSE, STEP_CLK, STAGE_NO, BTN_HELD
    );

    modport slave (
        input  RUNTYPE, STAGE_BTN,
        output STEP_PULSE, STEP_CLK, STAGE_NO, BTN_HELD
    );

endinterface

// File: rtl/step_clock_gen_btn_debounce.sv
// Stage button synchronizer and debounce FSM; emits a one-cycle
// strobe per accepted press and the debounced held level.
module step_clock_gen_btn_debounce
    import step_clock_gen_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic held,
    output logic strobe
);

    localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

    logic        btn_m;
    logic        btn_s;
    deb_state_t  state;
    deb_state_t  state_nx;
    logic [15:0] deb_cnt;
    logic [15:0] deb_cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
            state   <= S_IDLE;
            deb_cnt <= '0;
        end else begin
            btn_m   <= btn;
            btn_s   <= btn_m;
            state   <= state_nx;
            deb_cnt <= deb_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        deb_cnt_nx = deb_cnt;
        strobe     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (btn_s) begin
                    state_nx   = S_PRESS;
                    deb_cnt_nx = '0;
                end
            end
            S_PRESS: begin
                if (!btn_s) begin
                    state_nx = S_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = S_HELD;
                    strobe   = 1'b1;
                end else begin
                    deb_cnt_nx = deb_cnt + 16'd1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_nx   = S_RELEASE;
                    deb_cnt_nx = '0;
                end
            end
            S_RELEASE: begin
                // A bounce back high returns to held without a new step
                if (btn_s) begin
                    state_nx = S_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    deb_cnt_nx = deb_cnt + 16'd1;
                end
            end
        endcase
    end

    assign held = (state == S_HELD) || (state == S_RELEASE);

endmodule

// File: rtl/step_clock_gen.sv
// Stage-advance step generator: auto divider or debounced manual button.
// Define STEP_INSTR_EN to make one manual press run to the end of the instruction.
module step_clock_gen
    import step_clock_gen_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [31:0] AUTO_DIV   = 32'd25000000,
    parameter logic [7:0]  HIGH_CYC   = 8'd4
) (
    input logic             DCLK,
    input logic             RSTn,
    step_clock_gen_if.slave io
);

    logic        run_m;
    logic        run_s;
    logic        man_strobe;
    logic        held;
    logic [31:0] div_cnt;
    logic        auto_strobe;
    logic        strobe;
    logic        accept;
    logic        step_pulse;
    logic        step_clk;
    logic [7:0]  str_cnt;
    logic [2:0]  stage_no;

    step_clock_gen_btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk   (DCLK),
        .rst_n (RSTn),
        .btn   (io.STAGE_BTN),
        .held  (held),
        .strobe(man_strobe)
    );

    always_ff @(posedge DCLK or negedge RSTn) begin
        if (!RSTn) begin
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            run_m <= io.RUNTYPE;
            run_s <= run_m;
        end
    end

    assign auto_strobe = (run_s == RUN_AUTO) && (div_cnt == AUTO_DIV - 32'd1);

    always_ff @(posedge DCLK or negedge RSTn) begin
        if (!RSTn) begin
            div_cnt <= '0;
        end else if (run_s != RUN_AUTO || auto_strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

`ifdef STEP_INSTR_EN
    localparam logic [8:0] GAP = {HIGH_CYC, 1'b0};

    logic       burst;
    logic [8:0] gap_cnt;
    logic       burst_strobe;

    assign burst_strobe = burst && (gap_cnt == GAP);
    assign strobe = (run_s == RUN_AUTO) ? auto_strobe :
                    (burst ? burst_strobe : man_strobe);

    // Burst keeps stepping until the mirrored stage lands on STAGE_MAX
    always_ff @(posedge DCLK or negedge RSTn) begin
        if (!RSTn) begin
            burst   <= 1'b0;
            gap_cnt <= '0;
        end else if (run_s == RUN_AUTO) begin
            burst   <= 1'b0;
            gap_cnt <= '0;
        end else if (accept) begin
            burst   <= (stage_next(stage_no) != STAGE_MAX);
            gap_cnt <= 9'd1;
        end else if (burst) begin
            gap_cnt <= gap_cnt + 9'd1;
        end
    end
`else
    assign strobe = (run_s == RUN_AUTO) ? auto_strobe : man_strobe;
`endif

    // A strobe landing while the step clock is still high is dropped
    assign accept = strobe && !step_clk;

    always_ff @(posedge DCLK or negedge RSTn) begin
        if (!RSTn) begin
            step_pulse <= 1'b0;
            step_clk   <= 1'b0;
            str_cnt    <= '0;
            stage_no   <= '0;
        end else begin
            step_pulse <= accept;
            if (accept) begin
                step_clk <= 1'b1;
                str_cnt  <= 8'd1;
                stage_no <= stage_next(stage_no);
            end else if (step_clk) begin
                if (str_cnt == HIGH_CYC) begin
                    step_clk <= 1'b0;
                    str_cnt  <= '0;
                end else begin
                    str_cnt <= str_cnt + 8'd1;
                end
            end
        end
    end

    assign io.STEP_PULSE = step_pulse;
    assign io.STEP_CLK   = step_clk;
    assign io.STAGE_NO   = stage_no;
    assign io.BTN_HELD   = held;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: directed scenarios plus random button/mode
// traffic, every cycle compared with a run-length based reference model.
module tb_step_clock_gen;

    localparam int DEB = 4;
    localparam int DIV = 8;
    localparam int HC  = 2;

    logic DCLK = 1'b0;
    logic RSTn = 1'b0;

    step_clock_gen_if io();

    step_clock_gen #(
        .DEB_CYCLES(16'd4),
        .AUTO_DIV  (32'd8),
        .HIGH_CYC  (8'd2)
    ) dut (
        .DCLK(DCLK),
        .RSTn(RSTn),
        .io  (io)
    );

    always #5 DCLK = ~DCLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: inputs reach decisions two edges late; a press is
    // accepted after DEB+1 consecutive high samples, released after DEB+1 low.
    int sb1, sb2, sr1, sr2;
    int ones, zeros, a_age, edge_k, last_acc, burst_next;
    bit held_m, burst;
    logic m_pulse, m_clk, m_held;
    int m_stage;

    function automatic void model_reset();
        sb1 = 0; sb2 = 0; sr1 = 0; sr2 = 0;
        ones = 0; zeros = 0; a_age = 0; edge_k = 0;
        last_acc = -1000; burst_next = 0;
        held_m = 0; burst = 0;
        m_pulse = 0; m_clk = 0; m_held = 0; m_stage = 0;
    endfunction

    function automatic void model_step(input logic btn_in, input logic run_in);
        int b, r;
        bit man, aut, strb, acc, clk_pre;
        edge_k++;
        b = sb2; r = sr2;
        sb2 = sb1; sr2 = sr1;
        sb1 = int'(btn_in); sr1 = int'(run_in);
        man = 0;
        if (b != 0) begin ones++; zeros = 0; end
        else begin zeros++; ones = 0; end
        if (!held_m && ones == DEB + 1) begin
            held_m = 1; man = 1;
        end else if (held_m && zeros == DEB + 1) begin
            held_m = 0;
        end
        if (r != 0) a_age++; else a_age = 0;
        aut = (r != 0) && (a_age % DIV == 0);
        if (r != 0) burst = 0;
        if (r != 0) strb = aut;
        else if (burst) strb = (edge_k == burst_next);
        else strb = man;
        clk_pre = (edge_k - last_acc >= 1) && (edge_k - last_acc <= HC);
        acc = strb && !clk_pre;
        if (acc) begin
            last_acc = edge_k;
            m_stage = (m_stage >= 4) ? 1 : m_stage + 1;
`ifdef STEP_INSTR_EN
            if (r == 0) begin
                burst = (m_stage != 4);
                burst_next = edge_k + 2 * HC;
            end
`endif
        end
        m_pulse = acc;
        m_clk = (edge_k - last_acc >= 0) && (edge_k - last_acc < HC);
        m_held = held_m;
    endfunction

    int cyc = 0;
    int pulse_cnt = 0;
    int hi_run = 0;
    int stages[$];
    int widths[$];
    int pulse_t[$];

    task automatic tick();
        @(posedge DCLK);
        #1;
        cyc++;
        if (!RSTn) model_reset();
        else model_step(io.STAGE_BTN, io.RUNTYPE);
        check("step_pulse", io.STEP_PULSE, m_pulse);
        check("step_clk", io.STEP_CLK, m_clk);
        check("stage_no", io.STAGE_NO, m_stage);
        check("btn_held", io.BTN_HELD, m_held);
        if (io.STEP_PULSE === 1'b1) begin
            pulse_cnt++;
            stages.push_back(int'(io.STAGE_NO));
            pulse_t.push_back(cyc);
        end
        if (io.STEP_CLK === 1'b1) hi_run++;
        else if (hi_run > 0) begin
            widths.push_back(hi_run);
            hi_run = 0;
        end
    endtask

    task automatic drive_btn(input logic v, input int n);
        io.STAGE_BTN = v;
        repeat (n) tick();
    endtask

    task automatic wait_pulse(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (io.STEP_PULSE === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int s0;
    int first;
    int found;

    initial begin
        model_reset();
        io.RUNTYPE = 1'b0;
        io.STAGE_BTN = 1'b1;
        RSTn = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {26'd0, io.STEP_PULSE, io.STEP_CLK, io.STAGE_NO, io.BTN_HELD},
              32'd0);
        RSTn = 1'b1;
        wait_pulse(20, n);
        check("reset_latency", n, 7);
        check("reset_stage", io.STAGE_NO, 1);
        drive_btn(1'b0, 16);

        s0 = m_stage;
        pulse_cnt = 0;
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 1);
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 12);
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_stage", io.STAGE_NO, s0);

        RSTn = 1'b0;
        repeat (2) tick();
        RSTn = 1'b1;
        pulse_cnt = 0;
        stages.delete();
        widths.delete();
        hi_run = 0;
        repeat (5) begin
            drive_btn(1'b1, 8);
            drive_btn(1'b0, 8);
        end
        repeat (10) tick();
`ifndef STEP_INSTR_EN
        check("wrap_pulses", pulse_cnt, 5);
        for (int i = 0; i < 5; i++)
            check("wrap_stage", (i < stages.size()) ? stages[i] : 7, (i % 4) + 1);
`endif
        check("wrap_width_count", widths.size() >= 5, 1);
        foreach (widths[i]) check("wrap_width", widths[i], HC);

        pulse_cnt = 0;
        first = -1;
        io.RUNTYPE = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            io.STAGE_BTN = ((i >= 5 && i < 15) || (i >= 20 && i < 30));
            tick();
            if (io.STEP_PULSE === 1'b1 && first < 0) first = i;
        end
        io.STAGE_BTN = 1'b0;
        check("auto_first", first, 10);
        check("auto_pulses", pulse_cnt, 4);

        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut.div_cnt == 32'd5) begin
                found = 1;
                break;
            end
        end
        check("div_reach5", found, 1);
        io.RUNTYPE = 1'b0;
        pulse_cnt = 0;
        repeat (4) tick();
        check("div_cleared", dut.div_cnt, 0);
        repeat (16) tick();
        check("switch_no_pulse", pulse_cnt, 0);
        io.RUNTYPE = 1'b1;
        wait_pulse(20, n);
        check("reentry_latency", n, 10);
        io.RUNTYPE = 1'b0;
        repeat (12) tick();

        io.STAGE_BTN = 1'b1;
        wait_pulse(20, n);
        check("mid_press", n, 7);
        #3;
        RSTn = 1'b0;
        #1;
        check("mid_rst_clk", io.STEP_CLK, 0);
        check("mid_rst_pulse", io.STEP_PULSE, 0);
        check("mid_rst_stage", io.STAGE_NO, 0);
        check("mid_rst_held", io.BTN_HELD, 0);
        io.STAGE_BTN = 1'b0;
        repeat (2) tick();
        RSTn = 1'b1;
        pulse_cnt = 0;
        repeat (12) tick();
        check("rst_release_quiet", pulse_cnt, 0);

`ifdef STEP_INSTR_EN
        io.RUNTYPE = 1'b1;
        wait_pulse(20, n);
        io.RUNTYPE = 1'b0;
        repeat (12) tick();
        check("burst_start_stage", io.STAGE_NO, 1);
        pulse_cnt = 0;
        pulse_t.delete();
        drive_btn(1'b1, 8);
        drive_btn(1'b0, 24);
        check("burst_pulses", pulse_cnt, 3);
        for (int i = 1; i < pulse_t.size(); i++)
            check("burst_spacing", pulse_t[i] - pulse_t[i-1], 2 * HC);
        check("burst_end_stage", io.STAGE_NO, 4);
`endif

        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 7) == 0) io.RUNTYPE = ~io.RUNTYPE;
            io.STAGE_BTN = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
